// File: rtl/uart_receiver.sv
// UART receive path: RxD synchroniser, 16x baud tick generator and frame FSM.
// Frame: start(0), D0..D7 LSB first, even parity, stop(1). Result flags are levels
// that hold until the next accepted start edge or reset.
module uart_receiver #(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned SYNC_DEPTH = 2
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Rx_EN,
    input  logic       RxD,
    input  logic [2:0] baud_select,
    output logic [7:0] Rx_DATA,
    output logic       Rx_VALID,
    output logic       Rx_PERROR,
    output logic       Rx_FERROR
);

    // Rounded divisor for a 16x oversampling tick at the given baud rate.
    function automatic int unsigned baud_div(input int unsigned baud);
        return (CLK_HZ + 8 * baud) / (16 * baud);
    endfunction

    localparam int unsigned DIV_300    = baud_div(300);
    localparam int unsigned DIV_1200   = baud_div(1200);
    localparam int unsigned DIV_4800   = baud_div(4800);
    localparam int unsigned DIV_9600   = baud_div(9600);
    localparam int unsigned DIV_19200  = baud_div(19200);
    localparam int unsigned DIV_38400  = baud_div(38400);
    localparam int unsigned DIV_57600  = baud_div(57600);
    localparam int unsigned DIV_115200 = baud_div(115200);
    localparam int unsigned CNT_W      = (DIV_300 > 2) ? $clog2(DIV_300) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_e;

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  rxs_c;

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      div_max_c;
    logic [2:0]            sel_q;
    logic                  sel_chg_c;
    logic                  tick_c;
    logic                  restart_c;

    state_e                state_q, state_d;
    logic [3:0]            sc_q, sc_d;
    logic [2:0]            bi_q, bi_d;
    logic [7:0]            shift_q, shift_d;
    logic                  par_q, par_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  par_ok_c;

    assign rxs_c     = sync_q[SYNC_DEPTH-1];
    assign sel_chg_c = (baud_select != sel_q);
    assign tick_c    = (cnt_q == div_max_c);
    assign par_ok_c  = ((^shift_q) == par_q);

    assign Rx_DATA   = data_q;
    assign Rx_VALID  = valid_q;
    assign Rx_PERROR = perr_q;
    assign Rx_FERROR = ferr_q;

    // Terminal count of the tick counter for the selected baud rate.
    always_comb begin
        div_max_c = CNT_W'(DIV_9600 - 1);
        case (baud_select)
            3'd0:    div_max_c = CNT_W'(DIV_300 - 1);
            3'd1:    div_max_c = CNT_W'(DIV_1200 - 1);
            3'd2:    div_max_c = CNT_W'(DIV_4800 - 1);
            3'd3:    div_max_c = CNT_W'(DIV_9600 - 1);
            3'd4:    div_max_c = CNT_W'(DIV_19200 - 1);
            3'd5:    div_max_c = CNT_W'(DIV_38400 - 1);
            3'd6:    div_max_c = CNT_W'(DIV_57600 - 1);
            default: div_max_c = CNT_W'(DIV_115200 - 1);
        endcase
    end

    // Bring the asynchronous line into the Clk domain; idle level is high.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], RxD};
        end
    end

    // Baud tick counter; restarted on a start edge so ticks align to the frame.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sel_q <= 3'd0;
        end else begin
            sel_q <= baud_select;
            if (restart_c || sel_chg_c || tick_c) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Frame FSM next-state and result-flag logic; all decisions use rxs_c.
    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        bi_d      = bi_q;
        shift_d   = shift_q;
        par_d     = par_q;
        data_d    = data_q;
        valid_d   = valid_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        restart_c = 1'b0;

        if (!Rx_EN) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs_c) begin
                        state_d   = S_START;
                        sc_d      = 4'd0;
                        restart_c = 1'b1;
                        valid_d   = 1'b0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
                S_START: begin
                    if (tick_c) begin
                        sc_d = sc_q + 4'd1;
                        if (sc_q == 4'd7) begin
                            sc_d = 4'd0;
                            bi_d = 3'd0;
                            state_d = rxs_c ? S_IDLE : S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (tick_c) begin
                        sc_d = sc_q + 4'd1;
                        if (sc_q == 4'd15) begin
                            shift_d[bi_q] = rxs_c;
                            bi_d = bi_q + 3'd1;
                            if (bi_q == 3'd7) begin
                                state_d = S_PARITY;
                            end
                        end
                    end
                end
                S_PARITY: begin
                    if (tick_c) begin
                        sc_d = sc_q + 4'd1;
                        if (sc_q == 4'd15) begin
                            par_d   = rxs_c;
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (tick_c) begin
                        sc_d = sc_q + 4'd1;
                        if (sc_q == 4'd15) begin
                            if (rxs_c) begin
                                state_d = S_IDLE;
                                if (par_ok_c) begin
                                    data_d  = shift_q;
                                    valid_d = 1'b1;
                                end else begin
                                    perr_d = 1'b1;
                                end
                            end else begin
                                state_d = S_BREAK;
                                ferr_d  = 1'b1;
                                perr_d  = !par_ok_c;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    if (rxs_c) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Frame FSM state and output registers.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sc_q    <= 4'd0;
            bi_q    <= 3'd0;
            shift_q <= 8'h00;
            par_q   <= 1'b0;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sc_q    <= sc_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

endmodule
